// File: rtl/calendar_uart_tx_if.sv
// Report request, calendar date inputs and UART status for calendar_uart_tx.
// The bench drives through master; the transmitter uses slave.
interface calendar_uart_tx_if;
  logic       send;
  logic [6:0] day;
  logic [6:0] month;
  logic [6:0] year;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output send, day, month, year, input tx, busy, done);
  modport slave  (input send, day, month, year, output tx, busy, done);
endinterface

// File: rtl/calendar_uart_tx.sv
// Sends a "YY-MM-DD\r\n" date report over an 8N1 UART line.
// A rising edge on send starts the report, using a snapshot of the date taken at that edge.
module calendar_uart_tx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic                clk,
  input  logic                reset,
  calendar_uart_tx_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  byte_q, byte_d;
  logic [6:0]  day_q, day_d;
  logic [6:0]  month_q, month_d;
  logic [6:0]  year_q, year_d;
  logic        send_prev_q;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic [7:0]  cur_byte;
  logic [2:0]  next_bit;
  logic [15:0] year_pair, month_pair, day_pair;

  // Two ASCII digits of (v mod 100); v never exceeds 127, so one subtraction is enough.
  function automatic logic [15:0] ascii_pair(input logic [6:0] v);
    logic [6:0] m;
    logic [3:0] tens;
    logic [3:0] units;
    m     = (v >= 7'd100) ? v - 7'd100 : v;
    tens  = 4'(m / 7'd10);
    units = 4'(m % 7'd10);
    return {4'h3, tens, 4'h3, units};
  endfunction

  assign year_pair  = ascii_pair(year_q);
  assign month_pair = ascii_pair(month_q);
  assign day_pair   = ascii_pair(day_q);

  always_comb begin
    cur_byte = 8'h0A;
    case (byte_q)
      4'd0:    cur_byte = year_pair[15:8];
      4'd1:    cur_byte = year_pair[7:0];
      4'd2:    cur_byte = 8'h2D;
      4'd3:    cur_byte = month_pair[15:8];
      4'd4:    cur_byte = month_pair[7:0];
      4'd5:    cur_byte = 8'h2D;
      4'd6:    cur_byte = day_pair[15:8];
      4'd7:    cur_byte = day_pair[7:0];
      4'd8:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // Edges landing in the done cycle are dropped, not held for later.
  assign accept   = bus.send && !send_prev_q && (state_q == ST_IDLE) && !done_q;
  assign next_bit = bit_q + 3'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          byte_d  = 4'd0;
          day_d   = bus.day;
          month_d = bus.month;
          year_d  = bus.year;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        if (baud_q == BAUD_LAST) begin
          // Counter reloads on every bit boundary so timing never accumulates error.
          baud_d = 16'd0;
          case (state_q)
            ST_START: begin
              state_d = ST_DATA;
              bit_d   = 3'd0;
              tx_d    = cur_byte[0];
            end
            ST_DATA: begin
              if (bit_q == 3'd7) begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
              end else begin
                bit_d = next_bit;
                tx_d  = cur_byte[next_bit];
              end
            end
            default: begin
              if (byte_q < 4'd9) begin
                state_d = ST_START;
                byte_d  = byte_q + 4'd1;
                tx_d    = 1'b0;
              end else begin
                state_d = ST_IDLE;
                byte_d  = 4'd0;
                bit_d   = 3'd0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end
          endcase
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      baud_q      <= 16'd0;
      bit_q       <= 3'd0;
      byte_q      <= 4'd0;
      day_q       <= 7'd0;
      month_q     <= 7'd0;
      year_q      <= 7'd0;
      send_prev_q <= 1'b1;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      send_prev_q <= bus.send;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_calendar_uart_tx.sv
// Self-checking bench for calendar_uart_tx: fixed date vectors, reset corner cases
// and random dates, each report checked against an ideal 8N1 waveform built from the date.
module tb_calendar_uart_tx;
  localparam int BD   = 4;
  localparam int NCYC = 100 * BD;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  calendar_uart_tx_if bus ();

  calendar_uart_tx #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  d;
    logic [6:0]  m;
    logic [6:0]  y;
    bit          chg;
    int          edge_at;
    bit          done_edge;
    logic [79:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pair(input int v);
    int r;
    r = v % 100;
    return {8'(48 + r / 10), 8'(48 + r % 10)};
  endfunction

  function automatic logic [79:0] model_report(input int d, input int m, input int y);
    return {pair(y), 8'h2D, pair(m), 8'h2D, pair(d), 8'h0D, 8'h0A};
  endfunction

  // Raise send for one report and check the whole line waveform, busy and done.
  task automatic run_report(input logic [6:0] d, input logic [6:0] m, input logic [6:0] y,
                            input bit chg, input int edge_at, input bit done_edge,
                            input logic [79:0] exp);
    logic tx_s [NCYC + 2];
    int   busy_cnt, done_cnt, done_pos, wave_bad, first_bad;
    logic [7:0] eb, got;
    logic lvl;
    busy_cnt = 0; done_cnt = 0; done_pos = -1; wave_bad = 0; first_bad = -1;
    bus.send  = 1'b0;
    bus.day   = d;
    bus.month = m;
    bus.year  = y;
    @(negedge clk);
    bus.send = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NCYC + 2; i++) begin
      if (i > 0) @(negedge clk);
      tx_s[i] = bus.tx;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_pos = i;
      end
      if (i == 0) begin
        check("start_tx", 32'(bus.tx), 32'd0);
        check("start_busy", 32'(bus.busy), 32'd1);
      end
      if (i == NCYC + 1 && done_edge) begin
        check("done_cycle_edge_busy", 32'(bus.busy), 32'd0);
        check("done_cycle_edge_tx", 32'(bus.tx), 32'd1);
      end
      if (i == 2) bus.send = 1'b0;
      if (chg && i == 200) begin
        bus.day = 7'd1; bus.month = 7'd1; bus.year = 7'd0;
      end
      if (edge_at > 0 && i == edge_at) bus.send = 1'b1;
      if (edge_at > 0 && i == edge_at + 3) bus.send = 1'b0;
      if (done_edge && i == NCYC) bus.send = 1'b1;
    end
    for (int j = 0; j < 10; j++) begin
      eb  = exp[79 - 8 * j -: 8];
      got = 8'h00;
      for (int b = 0; b < 8; b++) got[b] = tx_s[j * 10 * BD + (b + 1) * BD + BD / 2];
      check($sformatf("byte%0d", j), 32'(got), 32'(eb));
      for (int k = 0; k < 10; k++) begin
        lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : eb[k - 1];
        for (int c = 0; c < BD; c++) begin
          if (tx_s[j * 10 * BD + k * BD + c] !== lvl) begin
            wave_bad++;
            if (first_bad < 0) first_bad = j * 10 * BD + k * BD + c;
          end
        end
      end
    end
    if (tx_s[NCYC] !== 1'b1) begin
      wave_bad++;
      if (first_bad < 0) first_bad = NCYC;
    end
    check($sformatf("wave_bad_cycles(first@%0d)", first_bad), 32'(wave_bad), 32'd0);
    check("busy_cycles", 32'(busy_cnt), 32'(NCYC));
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_pos", 32'(done_pos), 32'(NCYC));
    $display("report y=%0d m=%0d d=%0d expected=%h busy=%0d done=%0d", y, m, d, exp, busy_cnt, done_cnt);
  endtask

  vec_t tbl [4];

  initial begin
    int stuck;
    tbl[0] = '{d: 7'd2,  m: 7'd2,  y: 7'd24,  chg: 1'b0, edge_at: 0,   done_edge: 1'b0,
               exp: 80'h3234_2D_3032_2D_3032_0D0A};
    tbl[1] = '{d: 7'd31, m: 7'd12, y: 7'd99,  chg: 1'b1, edge_at: 0,   done_edge: 1'b0,
               exp: 80'h3939_2D_3132_2D_3331_0D0A};
    tbl[2] = '{d: 7'd7,  m: 7'd0,  y: 7'd105, chg: 1'b0, edge_at: 0,   done_edge: 1'b0,
               exp: 80'h3035_2D_3030_2D_3037_0D0A};
    tbl[3] = '{d: 7'd15, m: 7'd6,  y: 7'd7,   chg: 1'b0, edge_at: 150, done_edge: 1'b1,
               exp: 80'h3037_2D_3036_2D_3135_0D0A};

    bus.send = 1'b0; bus.day = 7'd0; bus.month = 7'd0; bus.year = 7'd0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(bus.tx), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 4; t++)
      run_report(tbl[t].d, tbl[t].m, tbl[t].y, tbl[t].chg, tbl[t].edge_at, tbl[t].done_edge, tbl[t].exp);

    // Abort mid-report with an asynchronous reset, then release it with send still high.
    bus.send = 1'b0; bus.day = 7'd9; bus.month = 7'd9; bus.year = 7'd9;
    @(negedge clk);
    bus.send = 1'b1;
    @(negedge clk);
    repeat (57) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_tx", 32'(bus.tx), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    stuck = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) stuck++;
    end
    check("held_send_no_start", 32'(stuck), 32'd0);
    $display("abort/release sequence done, active cycles after release=%0d", stuck);
    run_report(7'd9, 7'd9, 7'd9, 1'b0, 0, 1'b0, 80'h3039_2D_3039_2D_3039_0D0A);

    for (int r = 0; r < 6; r++) begin
      logic [6:0] rd, rm, ry;
      rd = 7'($urandom_range(0, 127));
      rm = 7'($urandom_range(0, 127));
      ry = 7'($urandom_range(0, 127));
      run_report(rd, rm, ry, ($urandom_range(0, 1) == 1), 0, 1'b0, model_report(rd, rm, ry));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
